// File: rtl/seven_seg_if.sv
// Bus between the display-path producer and the 7-segment scanner.
//  master: drives digit data, per-digit attributes, brightness and the load strobe.
//  slave : drives the cathode enables, the segment lines and the frame_done pulse.
interface seven_seg_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blank_lz;
  logic [3:0]              bright;
  logic                    load;
  logic [NUM_DIGITS-1:0]   cathode;
  logic [7:0]              segmentout;
  logic                    frame_done;

  modport master (
    output digits_in, dp_in, blink_mask, blank_lz, bright, load,
    input  cathode, segmentout, frame_done
  );

  modport slave (
    input  digits_in, dp_in, blink_mask, blank_lz, bright, load,
    output cathode, segmentout, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// N-digit multiplexed 7-segment scanner: one clock, tear-free shadow load,
// leading-zero blanking, per-digit blink, decimal points, PWM brightness.
//  clk, rst_n : system clock, asynchronous active-low reset
//  bus        : seven_seg_if slave side (digits_in/dp_in/blink_mask/blank_lz/bright/load in;
//               cathode/segmentout/frame_done out, all registered)
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD        = 16,
  parameter int unsigned BLINK_FRAMES = 128,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  seven_seg_if.slave bus
);
  localparam int unsigned PW   = $clog2(REFRESH_DIV);
  localparam int unsigned IW   = $clog2(NUM_DIGITS);
  localparam int unsigned FW   = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned DW   = 4 * NUM_DIGITS;
  localparam int unsigned SPAN = REFRESH_DIV - GUARD;
  localparam int unsigned MW   = PW + 5;

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         scan_idx;
  logic [FW-1:0]         frame_cnt;
  logic                  blink_phase;
  logic [DW-1:0]         stage_digits, shadow_digits;
  logic [NUM_DIGITS-1:0] stage_dp, shadow_dp;
  logic [NUM_DIGITS-1:0] stage_blink, shadow_blink;
  logic                  pending;
  logic [NUM_DIGITS-1:0] cathode_q;
  logic [7:0]            seg_q;
  logic                  frame_done_q;

  logic                  slot_wrap_c, frame_wrap_c;
  logic                  lit_c, lz_c, blink_off_c;
  logic [MW-1:0]         on_prod_c, win_end_c;
  logic [3:0]            nib_c;
  logic [NUM_DIGITS-1:0] cath_c;
  logic [7:0]            seg_c;

  // Hex to {g,f,e,d,c,b,a}, 1 = lit.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  assign slot_wrap_c  = (prescaler == PW'(REFRESH_DIV - 1));
  assign frame_wrap_c = slot_wrap_c && (scan_idx == IW'(NUM_DIGITS - 1));

  // Scan counters and blink timebase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      scan_idx    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      prescaler <= slot_wrap_c ? '0 : prescaler + PW'(1);
      if (slot_wrap_c)
        scan_idx <= frame_wrap_c ? '0 : scan_idx + IW'(1);
      if (frame_wrap_c) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // Staging/shadow: shadow only changes at a frame boundary, so a frame never mixes data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_digits  <= '0;
      stage_dp      <= '0;
      stage_blink   <= '0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blink  <= '0;
      pending       <= 1'b0;
    end else begin
      if (bus.load) begin
        stage_digits <= bus.digits_in;
        stage_dp     <= bus.dp_in;
        stage_blink  <= bus.blink_mask;
      end
      if (frame_wrap_c && pending) begin
        shadow_digits <= stage_digits;
        shadow_dp     <= stage_dp;
        shadow_blink  <= stage_blink;
      end
      if (bus.load)
        pending <= 1'b1;
      else if (frame_wrap_c)
        pending <= 1'b0;
    end
  end

  // Slot content: lit window, blanking and glyph for the digit being scanned.
  always_comb begin
    on_prod_c   = MW'(5'(bus.bright) + 5'd1) * MW'(SPAN);
    win_end_c   = MW'(GUARD) + (on_prod_c >> 4);
    lit_c       = (MW'(prescaler) >= MW'(GUARD)) && (MW'(prescaler) < win_end_c);
    nib_c       = shadow_digits[4*scan_idx +: 4];
    blink_off_c = blink_phase && shadow_blink[scan_idx];
    // Blank when this digit and every more-significant digit are zero; digit 0 always shows.
    lz_c = 1'b0;
    if (bus.blank_lz && (scan_idx != '0)) begin
      lz_c = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if ((i >= 32'(scan_idx)) && (shadow_digits[4*i +: 4] != 4'h0))
          lz_c = 1'b0;
      end
    end
    cath_c = '0;
    seg_c  = 8'h00;
    if (lit_c) begin
      cath_c[scan_idx] = 1'b1;
      if (blink_off_c)
        seg_c = 8'h00;
      else if (lz_c)
        seg_c = {shadow_dp[scan_idx], 7'h00};
      else
        seg_c = {shadow_dp[scan_idx], decode(nib_c)};
    end
  end

  // Registered outputs with board polarity applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cathode_q    <= {NUM_DIGITS{ACTIVE_LOW}};
      seg_q        <= {8{ACTIVE_LOW}};
      frame_done_q <= 1'b0;
    end else begin
      cathode_q    <= cath_c ^ {NUM_DIGITS{ACTIVE_LOW}};
      seg_q        <= seg_c ^ {8{ACTIVE_LOW}};
      frame_done_q <= frame_wrap_c;
    end
  end

  assign bus.cathode    = cathode_q;
  assign bus.segmentout = seg_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed scenarios plus random loads,
// compared every cycle against a timeline model derived from the cycle count since reset.
module tb_seven_seg_scanner;
  localparam int RD  = 40;
  localparam int GD  = 4;
  localparam int ND  = 4;
  localparam int BF  = 2;
  localparam int NRD = ND * RD;

  typedef struct {
    int          c;
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bm;
  } ld_t;

  logic clk;
  logic rst_n;
  seven_seg_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scanner #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          k     = 0;   // posedges since reset release
  ld_t         q[$];
  logic [15:0] m_d;
  logic [3:0]  m_dp, m_bm;
  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at k=%0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Expected pins for scan position s (cycles since release), active-low.
  function automatic void model_out(input int s, output int cath, output int seg);
    int p, idx, f, ph, win_end, nib, md, segv;
    bit lit, lz, boff, dpv;
    p       = s % RD;
    idx     = (s / RD) % ND;
    f       = s / NRD;
    ph      = (f / BF) % 2;
    win_end = GD + ((int'(bus.bright) + 1) * (RD - GD)) / 16;
    lit     = (p >= GD) && (p < win_end);
    cath = 15;
    seg  = 255;
    if (lit) begin
      md   = int'(m_d);
      nib  = (md >> (4 * idx)) % 16;
      dpv  = m_dp[idx];
      boff = (ph == 1) && m_bm[idx];
      lz   = bus.blank_lz && (idx != 0) && ((md >> (4 * idx)) == 0);
      if (boff)    segv = 0;
      else if (lz) segv = dpv ? 128 : 0;
      else         segv = (dpv ? 128 : 0) + int'(glyph[nib]);
      cath = 15 - (1 << idx);
      seg  = 255 - segv;
    end
  endfunction

  // One clock: advance, compare against the model for the state just left, log any load.
  task automatic cyc();
    int s, ec, es;
    @(posedge clk);
    #1;
    k++;
    s = k - 1;
    if (s % NRD == 0) begin
      while (q.size() > 0 && q[0].c <= s - 2) begin
        m_d  = q[0].d;
        m_dp = q[0].dp;
        m_bm = q[0].bm;
        void'(q.pop_front());
      end
    end
    model_out(s, ec, es);
    check("cathode", 32'(bus.cathode), 32'(ec));
    check("segmentout", 32'(bus.segmentout), 32'(es));
    check("frame_done", 32'(bus.frame_done), 32'((s % NRD) == NRD - 1));
    if (bus.load)
      q.push_back('{s, bus.digits_in, bus.dp_in, bus.blink_mask});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm);
    bus.digits_in  = d;
    bus.dp_in      = dp;
    bus.blink_mask = bm;
    bus.load       = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 1) r[4*i +: 4] = 4'($urandom_range(0, 15));
    return r;
  endfunction

  task automatic model_reset();
    k = 0;
    q.delete();
    m_d  = '0;
    m_dp = '0;
    m_bm = '0;
  endtask

  initial begin
    bool_found_init: begin end
    rst_n          = 1'b0;
    bus.digits_in  = '0;
    bus.dp_in      = '0;
    bus.blink_mask = '0;
    bus.blank_lz   = 1'b0;
    bus.bright     = 4'd15;
    bus.load       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cathode", 32'(bus.cathode), 32'h0000_000F);
    check("rst_segmentout", 32'(bus.segmentout), 32'h0000_00FF);
    check("rst_frame_done", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full brightness, 1234.
    do_load(16'h1234, 4'b0000, 4'b0000);
    run(360);

    // Leading-zero blanking on and off, including a dp on a blanked digit.
    bus.blank_lz = 1'b1;
    do_load(16'h0050, 4'b0100, 4'b0000);
    run(340);
    bus.blank_lz = 1'b0;
    run(200);
    bus.blank_lz = 1'b1;
    do_load(16'h0000, 4'b0000, 4'b0000);
    run(330);

    // Two loads mid-frame: only the last one is ever shown.
    run(37);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    run(4);
    do_load(16'hBBBB, 4'b1000, 4'b0000);
    run(400);

    // Brightness extremes.
    bus.bright = 4'd0;
    run(200);
    bus.bright = 4'd7;
    run(200);
    bus.bright = 4'd15;

    // Blink on digit 0 over several blink periods.
    do_load(16'h1234, 4'b0001, 4'b0001);
    run(900);

    // Load exactly on the wrap cycle, then another shortly after.
    for (int i = 0; i < 2 * NRD && (k % NRD) != NRD - 1; i++) cyc();
    do_load(16'h9876, 4'b0010, 4'b0000);
    run(3);
    do_load(16'hC0DE, 4'b0000, 4'b0100);
    run(400);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) bus.bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) bus.blank_lz = ~bus.blank_lz;
      if ($urandom_range(0, 39) == 0)
        do_load(rand_digits(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      else
        cyc();
    end

    // Reset in the middle of digit 2's slot.
    bus.bright = 4'd15;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
        if (((k / RD) % ND) == 2 && (k % RD) == 20) found = 1'b1;
        else cyc();
      end
      check("reach_digit2", 32'(found), 32'h1);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_cathode", 32'(bus.cathode), 32'h0000_000F);
    check("midrst_segmentout", 32'(bus.segmentout), 32'h0000_00FF);
    check("midrst_frame_done", 32'(bus.frame_done), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    run(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
